// File: rtl/rival_traffic_engine.sv
// Multi-rival traffic generator: LFSR lane spawning, tick scrolling, despawn scoring, player crash detect.
// Latency: pixel query registered 1 cycle after hor_pix/ver_pix; no backpressure, free-running.
module rival_traffic_engine #(
    parameter int         PIX_W          = 10,
    parameter int         NUM_RIVALS     = 4,
    parameter int         OFFSET_BG_X    = 200,
    parameter int         OFFSET_BG_Y    = 150,
    parameter int         BG_H           = 240,
    parameter int         CAR_W          = 14,
    parameter int         CAR_H          = 16,
    parameter int         ROAD_LEFT      = 44,
    parameter int         ROAD_RIGHT     = 104,
    parameter int         SPEED          = 2,
    parameter int         MOVE_COUNT_MAX = 1680000,
    parameter int         SPAWN_GAP      = 20,
    parameter logic [7:0] LFSR_SEED      = 8'hF3,
    parameter int         SCORE_W        = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [PIX_W-1:0]      player_x,
    input  logic [PIX_W-1:0]      player_y,
    input  logic [PIX_W-1:0]      hor_pix,
    input  logic [PIX_W-1:0]      ver_pix,
    output logic                  rival_on,
    output logic [7:0]            rival_rom_addr,
    output logic [2:0]            rival_idx,
    output logic                  collision,
    output logic [SCORE_W-1:0]    score,
    output logic [NUM_RIVALS-1:0] active_mask
);
    localparam int CW  = PIX_W + 1;
    localparam int TCW = (MOVE_COUNT_MAX > 0) ? $clog2(MOVE_COUNT_MAX + 1) : 1;
    localparam int GCW = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;
    localparam int LANE_BASE = OFFSET_BG_X + ROAD_LEFT;
    localparam int LANE_SPAN = ROAD_RIGHT - ROAD_LEFT + 1;
    localparam logic [CW-1:0] DESPAWN_Y = CW'(OFFSET_BG_Y + BG_H + CAR_H);

    typedef enum logic [1:0] {IDLE, RUN, CRASH} state_t;

    state_t                 state, state_nxt;
    logic [7:0]             lfsr;
    logic [TCW-1:0]         tick_cnt;
    logic [GCW-1:0]         gap_cnt, gap_nxt;
    logic [PIX_W-1:0]       pos_x [NUM_RIVALS];
    logic [PIX_W-1:0]       pos_y [NUM_RIVALS];
    logic [PIX_W-1:0]       x_nxt [NUM_RIVALS];
    logic [PIX_W-1:0]       y_nxt [NUM_RIVALS];
    logic [CW-1:0]          y_adv [NUM_RIVALS];
    logic [NUM_RIVALS-1:0]  active, act_nxt, spawn_oh;
    logic [3:0]             despawn_cnt;
    logic [SCORE_W:0]       score_sum;
    logic [SCORE_W-1:0]     score_nxt;
    logic [7:0]             lane_off;
    logic [PIX_W-1:0]       lane_x;
    logic [CW-1:0]          px, py, hx, vy;
    logic                   tick, spawn_now, hit;
    logic                   q_hit;
    logic [7:0]             q_addr;
    logic [2:0]             q_idx;

    assign px = CW'(player_x);
    assign py = CW'(player_y);
    assign hx = CW'(hor_pix);
    assign vy = CW'(ver_pix);

    assign lane_off  = lfsr % 8'(LANE_SPAN);
    assign lane_x    = PIX_W'(CW'(LANE_BASE) + CW'(lane_off));
    assign tick      = (state == RUN) && (tick_cnt == TCW'(MOVE_COUNT_MAX));
    // Lowest clear bit of the occupancy vector selects the spawn slot.
    assign spawn_oh  = ~active & (active + 1'b1);
    assign spawn_now = tick && (gap_cnt == '0) && (|spawn_oh);
    assign active_mask = active;

    // FSM: state register / next state / outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (start) state_nxt = RUN; else if (hit) state_nxt = CRASH;
            CRASH:   if (start) state_nxt = RUN;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb collision = (state == CRASH);

    always_comb begin
        for (int i = 0; i < NUM_RIVALS; i++) y_adv[i] = CW'(pos_y[i]) + CW'(SPEED);
    end

    always_comb begin
        act_nxt     = active;
        despawn_cnt = '0;
        gap_nxt     = gap_cnt;
        for (int i = 0; i < NUM_RIVALS; i++) begin
            x_nxt[i] = pos_x[i];
            y_nxt[i] = pos_y[i];
            if (tick && active[i]) begin
                if (y_adv[i] >= DESPAWN_Y) begin
                    act_nxt[i]  = 1'b0;
                    despawn_cnt = despawn_cnt + 4'd1;
                end else begin
                    y_nxt[i] = y_adv[i][PIX_W-1:0];
                end
            end
            if (spawn_now && spawn_oh[i]) begin
                act_nxt[i] = 1'b1;
                x_nxt[i]   = lane_x;
                y_nxt[i]   = PIX_W'(OFFSET_BG_Y);
            end
        end
        if (spawn_now)                  gap_nxt = GCW'(SPAWN_GAP - 1);
        else if (tick && gap_cnt != '0) gap_nxt = gap_cnt - 1'b1;
    end

    assign score_sum = {1'b0, score} + (SCORE_W+1)'(despawn_cnt);
    assign score_nxt = score_sum[SCORE_W] ? '1 : score_sum[SCORE_W-1:0];

    always_comb begin
        hit = 1'b0;
        for (int i = 0; i < NUM_RIVALS; i++) begin
            if (active[i] && (px < CW'(pos_x[i]) + CW'(CAR_W)) && (CW'(pos_x[i]) < px + CW'(CAR_W))
                && (py < CW'(pos_y[i])) && (CW'(pos_y[i]) - CW'(CAR_H) < py + CW'(CAR_H)))
                hit = 1'b1;
        end
    end

    // Walk from the top index down so the lowest matching slot is the one left standing.
    always_comb begin
        q_hit  = 1'b0;
        q_idx  = '0;
        q_addr = '0;
        for (int i = NUM_RIVALS - 1; i >= 0; i--) begin
            if (active[i] && hx >= CW'(pos_x[i]) && hx < CW'(pos_x[i]) + CW'(CAR_W)
                && vy >= CW'(pos_y[i]) - CW'(CAR_H) && vy < CW'(pos_y[i])) begin
                q_hit  = 1'b1;
                q_idx  = 3'(i);
                q_addr = 8'(hx - CW'(pos_x[i])) + 8'(CW'(CAR_W) * (vy - (CW'(pos_y[i]) - CW'(CAR_H))));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rival_on       <= 1'b0;
            rival_rom_addr <= '0;
            rival_idx      <= '0;
        end else begin
            rival_on <= q_hit;
            if (q_hit) begin
                rival_rom_addr <= q_addr;
                rival_idx      <= q_idx;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr     <= LFSR_SEED;
            tick_cnt <= '0;
            gap_cnt  <= '0;
            active   <= '0;
            score    <= '0;
            for (int i = 0; i < NUM_RIVALS; i++) begin
                pos_x[i] <= '0;
                pos_y[i] <= '0;
            end
        end else begin
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[2]};
            if (start) begin
                tick_cnt <= '0;
                gap_cnt  <= '0;
                active   <= '0;
                score    <= '0;
            end else if (state == RUN) begin
                tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
                gap_cnt  <= gap_nxt;
                active   <= act_nxt;
                score    <= score_nxt;
                for (int i = 0; i < NUM_RIVALS; i++) begin
                    pos_x[i] <= x_nxt[i];
                    pos_y[i] <= y_nxt[i];
                end
            end
        end
    end

endmodule

// File: doc/rival_traffic_engine.md
Name: rival_traffic_engine

Overview:
- Parametrised multi-rival traffic generator for the Road Fighter display path. It replaces the single hard-wired rival.
- Manages NUM_RIVALS independent rival cars: LFSR-randomised lane spawning, tick-based scrolling, despawn with score counting, and player-vs-rival collision.
- Answers a per-pixel query from the VGA pixel counters with a registered rival_on flag and sprite-ROM address, for the display mux downstream.

Parameters:
PIX_W, 10, width of pixel coordinates and car positions
NUM_RIVALS, 4, number of rival slots (1..8)
OFFSET_BG_X, 200, screen x of background left edge
OFFSET_BG_Y, 150, screen y of background top edge
BG_H, 240, background height in pixels
CAR_W, 14, car sprite width
CAR_H, 16, car sprite height
ROAD_LEFT, 44, leftmost rival x relative to OFFSET_BG_X
ROAD_RIGHT, 104, rightmost rival x relative to OFFSET_BG_X
SPEED, 2, pixels a rival advances per tick
MOVE_COUNT_MAX, 1680000, tick period minus one, in clk cycles
SPAWN_GAP, 20, minimum ticks between two spawns
LFSR_SEED, 8'hF3, non-zero LFSR reset value
SCORE_W, 16, score counter width

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
start  in  1  restart pulse (btnC level, synchronous)
player_x  in  PIX_W  player car left x
player_y  in  PIX_W  player car top y
hor_pix  in  PIX_W  current pixel x
ver_pix  in  PIX_W  current pixel y
rival_on  out  1  registered: pixel lies inside some active rival
rival_rom_addr  out  8  registered sprite ROM address for that rival
rival_idx  out  3  registered index of the rival that is drawn
collision  out  1  high while in CRASH
score  out  SCORE_W  rivals passed, saturating
active_mask  out  NUM_RIVALS  slot occupancy

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; all slots inactive; score=0; collision=0; rival_on=0; rival_rom_addr=0; rival_idx=0.
  - tick counter=0; spawn-gap counter=0; LFSR=LFSR_SEED.
- LFSR:
  - 8-bit, feedback = q[7]^q[5]^q[4]^q[2], shifted in at bit 0 every clk in every state.
  - Spawn lane: x = OFFSET_BG_X + ROAD_LEFT + (q % (ROAD_RIGHT-ROAD_LEFT+1)).
- Rival geometry:
  - Per slot: x, y (PIX_W) and an active bit.
  - The sprite occupies columns x..x+CAR_W-1 and rows y-CAR_H..y-1; y is the exclusive bottom edge.
- State machine IDLE/RUN/CRASH:
  - IDLE: nothing moves. start -> RUN.
  - RUN: ticking, spawning and collision checking. Overlap -> CRASH. start -> RUN restart.
  - CRASH: all positions and score frozen; collision=1. start -> RUN restart.
  - Restart (start=1 in any state): next cycle all slots inactive, score=0, tick and gap counters=0, collision=0. start has priority over a same-cycle collision or tick.
- Tick:
  - In RUN, the counter counts 0..MOVE_COUNT_MAX; tick is the cycle where counter==MOVE_COUNT_MAX, then the counter wraps to 0.
  - On tick, every active slot does y <= y+SPEED.
  - If the new y >= OFFSET_BG_Y+BG_H+CAR_H, the slot goes inactive instead and score increments, saturating at all-ones.
  - Several despawns on the same tick add their count to score.
- Spawn:
  - On tick, when gap counter==0 and at least one slot is inactive (evaluated before that tick's despawns), the lowest-index inactive slot becomes active with the LFSR lane x and y=OFFSET_BG_Y.
  - The gap counter then loads SPAWN_GAP-1 and decrements once per tick down to 0.
  - With all slots full, no spawn happens and the gap counter holds at 0.
- Collision:
  - Evaluated every cycle in RUN using the current registered positions.
  - For any active slot, boxes overlap when player_x < x+CAR_W, x < player_x+CAR_W, player_y < y, and y-CAR_H < player_y+CAR_H (strict inequalities, so touching edges do not collide).
  - The transition to CRASH takes effect next cycle. The tick in that same cycle still applies.
- Pixel query, 1-cycle latency:
  - Outputs are registered from hor_pix/ver_pix sampled in the previous cycle.
  - The lowest-index active slot containing the pixel wins. rival_rom_addr = (hor_pix-x) + CAR_W*(ver_pix-(y-CAR_H)), truncated to 8 bits.
  - With no hit, rival_on=0 and rival_rom_addr/rival_idx hold their previous values.
  - Pixel query runs in all states, so frozen cars remain visible in CRASH.
- Width rules:
  - All coordinate arithmetic is done at PIX_W+1 bits to avoid wrap on y-CAR_H and x+CAR_W.
  - Parameters must satisfy OFFSET_BG_Y >= CAR_H.

Test Plan:
1. rst_n low mid-RUN with 2 slots active -> outputs immediately return to reset values: active_mask=0, score=0, collision=0.
2. Sim parameters MOVE_COUNT_MAX=3, SPAWN_GAP=2, start pulse -> first spawn on the tick at cycle 4 with slot0 y=150 and x in 244..304; the next spawn (slot1) comes 2 ticks later; slot0 y=152 after one more tick.
3. Park a single rival until y reaches 404 (150+240+16-2 plus SPEED) -> slot goes inactive on that tick; score 0->1; fill all 4 slots -> no 5th spawn and the gap counter holds at 0.
4. Player at (270,300) and rival x=270, y reaching 301 -> collision=1 the next cycle and positions frozen; with y=300 (touching edge) -> no collision.
5. Rivals 0 and 1 overlapping at pixel (275,290) -> one cycle later rival_on=1, rival_idx=0, and the address is computed from slot0; a pixel outside all rivals -> rival_on=0.
6. start asserted in CRASH on the same cycle as a tick -> next cycle state=RUN, active_mask=0, score=0, collision=0.
